// File: rtl/nibble_op_sequencer.sv
// Front-end sequencer for the nibble loop: accepts one ALU operation, arms and runs the loop
// (several passes for multi-bit right shifts) and returns result, flag and error.
package nibble_op_pkg;

    typedef enum logic [2:0] {
        CMD_ADD   = 3'd0,
        CMD_SUB   = 3'd1,
        CMD_CMP   = 3'd2,
        CMD_EQ    = 3'd3,
        CMD_RSHFT = 3'd4
    } alu_cmd_e;

    typedef struct packed {
        alu_cmd_e cmd;
        logic     carry_in;
        logic     b_inv;
        logic     carry_disable;
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_CMP = 3'd2;
    localparam logic [2:0] OP_EQ  = 3'd3;
    localparam logic [2:0] OP_SHR = 3'd4;

endpackage

module nibble_op_sequencer
    import nibble_op_pkg::*;
#(
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    // Both ports: a transfer happens on a posedge where valid && ready; the sender holds
    // its payload stable while valid is high and ready is low, and never drops valid early.
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_op,
    input  logic [2:0]         req_nibbles,
    input  logic               req_b_signed_neg,
    input  logic [SHAMT_W-1:0] req_shamt,
    input  logic [31:0]        req_a,
    input  logic [31:0]        req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_result,
    output logic               rsp_flag,
    output logic               rsp_err,
    output logic               loop_perm_to_count,
    output logic [2:0]         loop_nibbles_number,
    output alu_ctrl_t          loop_ctrl,
    output logic               loop_check_0xf,
    output logic               loop_b_signed_neg,
    output logic [31:0]        loop_word1,
    output logic [31:0]        loop_word2,
    output logic               loop_preinit_only,
    output logic [31:0]        loop_preinit_result,
    input  logic               loop_busy,
    input  logic               loop_carry,
    input  logic [31:0]        loop_result,
    output seq_state_e         dbg_state
);

    seq_state_e         state_q;
    logic [2:0]         op_q;
    logic [SHAMT_W-1:0] passes_q;
    logic               first_q;
    logic               bypass_q;
    logic               perm_q;
    logic [2:0]         nib_q;
    alu_ctrl_t          ctrl_q;
    logic               chk_q;
    logic               neg_q;
    logic [31:0]        word1_q;
    logic [31:0]        word2_q;
    logic               pre_only_q;
    logic [31:0]        pre_res_q;
    logic               rsp_valid_q;
    logic [31:0]        rsp_result_q;
    logic               rsp_flag_q;
    logic               rsp_err_q;

    logic               op_illegal_d;
    logic               is_shr_d;
    logic               shamt_zero_d;
    logic               shr_bypass_d;

    always_comb begin
        op_illegal_d = (req_op > OP_SHR);
        is_shr_d     = (req_op == OP_SHR);
        shamt_zero_d = (req_shamt == '0);
        // Zero or overlong shifts need no loop pass: the answer is known at accept time.
        shr_bypass_d = is_shr_d && (shamt_zero_d || (32'(req_shamt) >= 32'd32));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            passes_q     <= '0;
            first_q      <= 1'b0;
            bypass_q     <= 1'b0;
            perm_q       <= 1'b0;
            nib_q        <= '0;
            ctrl_q       <= '0;
            chk_q        <= 1'b0;
            neg_q        <= 1'b0;
            word1_q      <= '0;
            word2_q      <= '0;
            pre_only_q   <= 1'b0;
            pre_res_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flag_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q         <= req_op;
                        rsp_result_q <= '0;
                        rsp_flag_q   <= 1'b0;
                        rsp_err_q    <= 1'b0;
                        if (op_illegal_d) begin
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            word1_q    <= req_a;
                            word2_q    <= req_b;
                            neg_q      <= req_b_signed_neg;
                            passes_q   <= req_shamt;
                            chk_q      <= (req_op == OP_EQ);
                            nib_q      <= is_shr_d ? 3'd7 : req_nibbles;
                            ctrl_q     <= '{cmd: alu_cmd_e'(req_op), carry_in: 1'b0,
                                            b_inv: 1'b0, carry_disable: 1'b0};
                            bypass_q   <= shr_bypass_d;
                            pre_only_q <= shr_bypass_d;
                            if (!is_shr_d) begin
                                pre_res_q <= req_a;
                            end else if (shr_bypass_d && shamt_zero_d) begin
                                pre_res_q <= req_b;
                            end else begin
                                pre_res_q <= '0;
                            end
                            state_q    <= ST_ARM;
                        end
                    end
                end
                ST_ARM: begin
                    if (bypass_q) begin
                        pre_only_q   <= 1'b0;
                        rsp_result_q <= pre_res_q;
                        rsp_flag_q   <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= ST_DONE;
                    end else begin
                        perm_q  <= 1'b1;
                        first_q <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    first_q <= 1'b0;
                    // The loop's busy lags the count permission by a cycle, so skip it once.
                    if (!first_q && !loop_busy) begin
                        perm_q <= 1'b0;
                        if (op_q == OP_SHR && passes_q > SHAMT_W'(1)) begin
                            word2_q  <= loop_result;
                            passes_q <= passes_q - SHAMT_W'(1);
                            state_q  <= ST_ARM;
                        end else begin
                            rsp_result_q <= loop_result;
                            rsp_flag_q   <= (op_q == OP_SHR) ? 1'b0 : loop_carry;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready           = (state_q == ST_IDLE);
    assign rsp_valid           = rsp_valid_q;
    assign rsp_result          = rsp_result_q;
    assign rsp_flag            = rsp_flag_q;
    assign rsp_err             = rsp_err_q;
    assign loop_perm_to_count  = perm_q;
    assign loop_nibbles_number = nib_q;
    assign loop_ctrl           = ctrl_q;
    assign loop_check_0xf      = chk_q;
    assign loop_b_signed_neg   = neg_q;
    assign loop_word1          = word1_q;
    assign loop_word2          = word2_q;
    assign loop_preinit_only   = pre_only_q;
    assign loop_preinit_result = pre_res_q;
    assign dbg_state           = state_q;

endmodule

// File: tb/tb_nibble_op_sequencer.sv
// Bench for nibble_op_sequencer: behavioural nibble loop, directed requests, queue scoreboard.
module tb_nibble_op_sequencer;
    import nibble_op_pkg::*;

    localparam int SHAMT_W = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               req_valid;
    logic               req_ready;
    logic [2:0]         req_op;
    logic [2:0]         req_nibbles;
    logic               req_b_signed_neg;
    logic [SHAMT_W-1:0] req_shamt;
    logic [31:0]        req_a;
    logic [31:0]        req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_result;
    logic               rsp_flag;
    logic               rsp_err;
    logic               loop_perm_to_count;
    logic [2:0]         loop_nibbles_number;
    alu_ctrl_t          loop_ctrl;
    logic               loop_check_0xf;
    logic               loop_b_signed_neg;
    logic [31:0]        loop_word1;
    logic [31:0]        loop_word2;
    logic               loop_preinit_only;
    logic [31:0]        loop_preinit_result;
    logic               loop_busy;
    logic               loop_carry;
    logic [31:0]        loop_result;
    seq_state_e         dbg_state;

    int          n_checks = 0;
    int          n_miss = 0;
    logic [33:0] exp_q[$];
    logic [33:0] exp_e;
    int          pass_cnt = 0;
    logic        perm_prev = 1'b0;
    logic [2:0]  cap_nib;
    logic [5:0]  cap_ctrl;
    logic        cap_chk;
    logic [31:0] cap_preinit;

    nibble_op_sequencer #(.SHAMT_W(SHAMT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_nibbles(req_nibbles), .req_b_signed_neg(req_b_signed_neg),
        .req_shamt(req_shamt), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flag(rsp_flag), .rsp_err(rsp_err),
        .loop_perm_to_count(loop_perm_to_count), .loop_nibbles_number(loop_nibbles_number),
        .loop_ctrl(loop_ctrl), .loop_check_0xf(loop_check_0xf),
        .loop_b_signed_neg(loop_b_signed_neg), .loop_word1(loop_word1),
        .loop_word2(loop_word2), .loop_preinit_only(loop_preinit_only),
        .loop_preinit_result(loop_preinit_result), .loop_busy(loop_busy),
        .loop_carry(loop_carry), .loop_result(loop_result), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end of test, want summary");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural nibble loop ----------------
    // Busy rises one cycle after count permission, stays high for nibbles+1 cycles.
    logic       mdl_started;
    logic [2:0] mdl_cnt;

    function automatic logic [32:0] loop_model();
        int          w;
        logic [31:0] m;
        logic [32:0] sum;
        logic        c;
        logic [31:0] r;
        w   = 4 * (int'(loop_nibbles_number) + 1);
        m   = (w == 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
        sum = '0;
        c   = 1'b0;
        r   = loop_preinit_result;
        case (loop_ctrl.cmd)
            CMD_ADD: sum = {1'b0, loop_word1 & m} + {1'b0, loop_word2 & m};
            CMD_SUB: sum = {1'b0, loop_word1 & m} + {1'b0, ~loop_word2 & m} + 33'd1;
            CMD_CMP: sum = {1'b0, loop_word1 & m} + {1'b0, ~loop_word2 & m};
            default: sum = '0;
        endcase
        case (loop_ctrl.cmd)
            CMD_ADD, CMD_SUB, CMD_CMP: begin
                c = sum[w];
                r = (sum[31:0] & m) | (loop_preinit_result & ~m);
            end
            CMD_EQ: begin
                c = (((loop_word1 ^ loop_word2) & m) == 32'd0);
                r = loop_preinit_result;
            end
            CMD_RSHFT: begin
                c = 1'b0;
                r = loop_word2 >> 1;
            end
            default: begin
                c = 1'b0;
                r = '0;
            end
        endcase
        return {c, r};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loop_busy   <= 1'b0;
            loop_carry  <= 1'b0;
            loop_result <= '0;
            mdl_started <= 1'b0;
            mdl_cnt     <= '0;
        end else if (!loop_perm_to_count) begin
            loop_busy   <= 1'b0;
            mdl_started <= 1'b0;
        end else if (!mdl_started) begin
            mdl_started <= 1'b1;
            loop_busy   <= 1'b1;
            mdl_cnt     <= loop_nibbles_number;
        end else if (loop_busy) begin
            if (mdl_cnt == 3'd0) begin
                loop_busy                 <= 1'b0;
                {loop_carry, loop_result} <= loop_model();
            end else begin
                mdl_cnt <= mdl_cnt - 3'd1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_miss++;
                $display("FAIL rsp_unexpected: got result %h with no pending request, want none",
                         rsp_result);
            end else begin
                exp_e = exp_q.pop_front();
                check("rsp_result", rsp_result, exp_e[33:2]);
                check("rsp_flag", 32'(rsp_flag), 32'(exp_e[1]));
                check("rsp_err", 32'(rsp_err), 32'(exp_e[0]));
            end
        end
        if (loop_perm_to_count && !perm_prev) begin
            pass_cnt++;
            cap_nib     = loop_nibbles_number;
            cap_ctrl    = loop_ctrl;
            cap_chk     = loop_check_0xf;
            cap_preinit = loop_preinit_result;
        end
        perm_prev = loop_perm_to_count;
    end

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic [2:0] op, input logic [2:0] nib, input logic neg,
                            input logic [SHAMT_W-1:0] sh, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] er, input logic ef,
                            input logic ee, input bit expect_rsp);
        int waited;
        waited = 0;
        while (!req_ready && waited < 3000) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!req_ready) begin
            n_checks++;
            n_miss++;
            $display("FAIL req_ready_timeout: got req_ready 0 after %0d cycles, want 1", waited);
            return;
        end
        pass_cnt         = 0;
        req_valid        = 1'b1;
        req_op           = op;
        req_nibbles      = nib;
        req_b_signed_neg = neg;
        req_shamt        = sh;
        req_a            = a;
        req_b            = b;
        if (expect_rsp) exp_q.push_back({er, ef, ee});
        @(posedge clk); #1;
        // Scramble the request bus so any late sampling shows up as a wrong answer.
        req_valid        = 1'b0;
        req_op           = 3'd0;
        req_nibbles      = ~nib;
        req_b_signed_neg = ~neg;
        req_shamt        = ~sh;
        req_a            = ~a;
        req_b            = b ^ 32'h5a5a_5a5a;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 3000) begin
            @(posedge clk); #1;
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_miss++;
            $display("FAIL rsp_timeout: got %0d pending responses, want 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic cycles_to_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // ---------------- stimulus ----------------
    int lat;

    initial begin
        req_valid        = 1'b0;
        req_op           = '0;
        req_nibbles      = '0;
        req_b_signed_neg = 1'b0;
        req_shamt        = '0;
        req_a            = '0;
        req_b            = '0;
        rsp_ready        = 1'b1;
        rst_n            = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_perm", 32'(loop_perm_to_count), 32'd0);
        check("reset_rsp_result", rsp_result, 32'd0);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD on a single nibble: upper nibbles come from A through the preinit path.
        send_req(OP_ADD, 3'd0, 1'b0, 5'd0, 32'h00ff_0004, 32'h0000_0004, 32'h00ff_0008, 1'b0, 1'b0, 1'b1);
        cycles_to_rsp(lat);
        check("add_latency", 32'(lat), 32'd4);
        drain();
        check("add_preinit", cap_preinit, 32'h00ff_0004);

        send_req(OP_SUB, 3'd7, 1'b0, 5'd0, 32'h0000_1000, 32'h0000_0500, 32'h0000_0b00, 1'b1, 1'b0, 1'b1);
        drain();
        send_req(OP_CMP, 3'd7, 1'b0, 5'd0, 32'h1234_1234, 32'h1234_1234, 32'hffff_ffff, 1'b0, 1'b0, 1'b1);
        drain();
        check("cmp_ctrl", 32'(cap_ctrl), 32'({CMD_CMP, 3'b000}));

        send_req(OP_EQ, 3'd7, 1'b0, 5'd0, 32'h1234_1234, 32'h1234_1234, 32'h1234_1234, 1'b1, 1'b0, 1'b1);
        drain();
        check("eq_check_0xf", 32'(cap_chk), 32'd1);
        send_req(OP_EQ, 3'd7, 1'b0, 5'd0, 32'h2234_1234, 32'h1234_1234, 32'h2234_1234, 1'b0, 1'b0, 1'b1);
        drain();
        // Only nibbles 0..6 compared, so the differing top nibble is invisible.
        send_req(OP_EQ, 3'd6, 1'b0, 5'd0, 32'h2234_1234, 32'h1234_1234, 32'h2234_1234, 1'b1, 1'b0, 1'b1);
        drain();

        send_req(OP_SHR, 3'd2, 1'b0, 5'd3, 32'hffff_ffff, 32'h0600_0000, 32'h00c0_0000, 1'b0, 1'b0, 1'b1);
        drain();
        check("shr3_passes", 32'(pass_cnt), 32'd3);
        check("shr3_nibbles", 32'(cap_nib), 32'd7);
        check("shr3_cmd", 32'(cap_ctrl[5:3]), 32'(CMD_RSHFT));
        check("shr3_check_0xf", 32'(cap_chk), 32'd0);
        check("shr3_preinit", cap_preinit, 32'd0);

        send_req(OP_SHR, 3'd0, 1'b0, 5'd0, 32'h1111_1111, 32'ha5a5_0f0f, 32'ha5a5_0f0f, 1'b0, 1'b0, 1'b1);
        check("shr0_preinit_only", 32'(loop_preinit_only), 32'd1);
        check("shr0_preinit_val", loop_preinit_result, 32'ha5a5_0f0f);
        check("shr0_rsp_early", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("shr0_rsp_valid", 32'(rsp_valid), 32'd1);
        check("shr0_pulse_end", 32'(loop_preinit_only), 32'd0);
        drain();
        check("shr0_passes", 32'(pass_cnt), 32'd0);

        send_req(OP_SHR, 3'd0, 1'b0, 5'd1, 32'h0, 32'h8000_0001, 32'h4000_0000, 1'b0, 1'b0, 1'b1);
        drain();
        check("shr1_passes", 32'(pass_cnt), 32'd1);
        send_req(OP_SHR, 3'd0, 1'b0, 5'd31, 32'h0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        drain();
        check("shr31_passes", 32'(pass_cnt), 32'd31);

        // Consumer stalls: response must hold steady and no new request may be taken.
        rsp_ready = 1'b0;
        send_req(OP_ADD, 3'd3, 1'b0, 5'd0, 32'h0000_1234, 32'h0000_0fff, 32'h0000_2233, 1'b0, 1'b0, 1'b1);
        cycles_to_rsp(lat);
        for (int i = 0; i < 5; i++) begin
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_result", rsp_result, 32'h0000_2233);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        drain();

        send_req(3'd6, 3'd7, 1'b0, 5'd0, 32'h1234_5678, 32'h9abc_def0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("illegal_rsp_now", 32'(rsp_valid), 32'd1);
        drain();
        send_req(3'd7, 3'd1, 1'b0, 5'd0, 32'hffff_ffff, 32'h1, 32'h0, 1'b0, 1'b1, 1'b1);
        drain();

        // Reset in the middle of a long shift drops the pending response.
        send_req(OP_SHR, 3'd0, 1'b0, 5'd20, 32'h0, 32'hffff_0000, 32'h0, 1'b0, 1'b0, 1'b0);
        lat = 0;
        while (dbg_state != ST_RUN && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_perm", 32'(loop_perm_to_count), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;

        send_req(OP_ADD, 3'd7, 1'b0, 5'd0, 32'hffff_ffff, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
        $finish;
    end

endmodule
